host_frame_rebuild: RTL and testbench

- Downstream of the host-side frame inverse-mapping stage; consumes one lookup result per fragment (dmac, bufid, match flag, dmac-replace flag).
- Fetches the fragment from the packet buffer and prepends a 16B metadata word.
- On first fragments, overwrites the TSN tag with the real DMAC; on middle/last fragments, drops the leading 16B header word.
- Streams the result to the host output FIFO, then releases the buffer.

---
 rtl/host_frame_rebuild.sv | 222 ++++++++++++++++++++++
 tb/tb_host_frame_rebuild.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_frame_rebuild.sv
// host_frame_rebuild: rebuilds host-bound frames from inverse-mapped fragments.
// For each lookup result it fetches the fragment from the packet buffer and
// prepends a 16B metadata word. On first fragments the TSN tag is overwritten
// with the real DMAC; on middle/last fragments the leading header word is
// dropped. The result goes to the host FIFO, then the buffer is released.
//
// Metadata timing:
//   * replace=1 (first fragment): the frame can no longer be dropped once the
//     read is issued, so metadata is sent together with the read request.
//   * replace=0: the first buffer word is discarded anyway, so metadata takes
//     its slot. If that word is also the tail, the fragment is metadata-only
//     and is dropped, and the metadata is never sent.
//   Either way a dropped frame never produces output, and all outputs stay in
//   order without an extra holding buffer.
module host_frame_rebuild #(
    parameter int DATA_W  = 134,
    parameter int BUFID_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [47:0]        iv_dmac,
    input  logic [BUFID_W-1:0] iv_bufid,
    input  logic               i_lookup_table_match_flag,
    input  logic               i_dmac_replace_flag,
    input  logic               i_descriptor_wr,
    output logic               o_descriptor_ready,
    output logic [BUFID_W-1:0] ov_pkt_rd_bufid,
    output logic               o_pkt_rd,
    input  logic [DATA_W-1:0]  iv_pkt_data,
    input  logic               i_pkt_data_wr,
    output logic [BUFID_W-1:0] ov_free_bufid,
    output logic               o_free_bufid_wr,
    input  logic               i_fifo_afull,
    output logic [DATA_W-1:0]  ov_data,
    output logic               o_data_wr,
    output logic [CNT_W-1:0]   ov_frame_cnt,
    output logic [CNT_W-1:0]   ov_drop_cnt
);

    // Field positions inside a packet word
    localparam int TAIL_BIT = DATA_W - 1;
    localparam int HEAD_BIT = DATA_W - 2;
    localparam int DMAC_HI  = 127;
    localparam int DMAC_LO  = 80;
    localparam int MBUF_HI  = 79;
    localparam int MREP_BIT = MBUF_HI - BUFID_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FIRST,
        S_BODY,
        S_DROP,
        S_RELEASE
    } state_t;

    state_t              r_state;
    logic [47:0]         r_dmac;
    logic [BUFID_W-1:0]  r_bufid;
    logic                r_match;
    logic                r_replace;
    logic                r_fwd;        // frame has produced output -> counts as forwarded
    logic                r_ready;
    logic                r_pkt_rd;
    logic [BUFID_W-1:0]  r_rd_bufid;
    logic                r_free_wr;
    logic [BUFID_W-1:0]  r_free_bufid;
    logic [DATA_W-1:0]   r_data;
    logic                r_data_wr;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;

    // Descriptor fields: straight from the inputs in IDLE (accept and issue
    // in the same cycle), from the latched copy otherwise.
    logic                w_in_idle;
    logic [47:0]         w_sel_dmac;
    logic [BUFID_W-1:0]  w_sel_bufid;
    logic                w_sel_match;
    logic                w_sel_replace;
    logic                w_tail;
    logic                w_frame_state;
    logic [DATA_W-1:0]   w_meta;
    logic [DATA_W-1:0]   w_repl_word;

    assign w_in_idle     = (r_state == S_IDLE);
    assign w_sel_dmac    = w_in_idle ? iv_dmac                   : r_dmac;
    assign w_sel_bufid   = w_in_idle ? iv_bufid                  : r_bufid;
    assign w_sel_match   = w_in_idle ? i_lookup_table_match_flag : r_match;
    assign w_sel_replace = w_in_idle ? i_dmac_replace_flag       : r_replace;
    assign w_tail        = iv_pkt_data[TAIL_BIT];
    assign w_frame_state = (r_state == S_FIRST) || (r_state == S_BODY) ||
                           (r_state == S_DROP);

    // Metadata word: head flag, zero invalid bytes, dmac, bufid, replace flag
    always_comb begin
        w_meta                    = '0;
        w_meta[TAIL_BIT:HEAD_BIT] = 2'b01;
        w_meta[DMAC_HI:DMAC_LO]   = w_sel_dmac;
        w_meta[MBUF_HI -: BUFID_W] = w_sel_bufid;
        w_meta[MREP_BIT]          = w_sel_replace;
    end

    // First word of a first fragment: tag replaced by dmac, head flag cleared
    always_comb begin
        w_repl_word                  = iv_pkt_data;
        w_repl_word[DMAC_HI:DMAC_LO] = r_dmac;
        w_repl_word[HEAD_BIT]        = 1'b0;
    end

    // Control FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_dmac       <= '0;
            r_bufid      <= '0;
            r_match      <= 1'b0;
            r_replace    <= 1'b0;
            r_fwd        <= 1'b0;
            r_ready      <= 1'b1;
            r_pkt_rd     <= 1'b0;
            r_rd_bufid   <= '0;
            r_free_wr    <= 1'b0;
            r_free_bufid <= '0;
            r_data       <= '0;
            r_data_wr    <= 1'b0;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_pkt_rd  <= 1'b0;
            r_data_wr <= 1'b0;
            r_free_wr <= 1'b0;

            case (r_state)
                S_IDLE, S_REQ: begin
                    if (r_state == S_REQ || i_descriptor_wr) begin
                        if (w_in_idle) begin
                            r_dmac    <= iv_dmac;
                            r_bufid   <= iv_bufid;
                            r_match   <= i_lookup_table_match_flag;
                            r_replace <= i_dmac_replace_flag;
                        end
                        r_ready <= 1'b0;
                        r_fwd   <= 1'b0;
                        if (i_fifo_afull) begin
                            r_state <= S_REQ;
                        end else begin
                            r_pkt_rd   <= 1'b1;
                            r_rd_bufid <= w_sel_bufid;
                            if (w_sel_match) begin
                                r_state <= S_FIRST;
                                if (w_sel_replace) begin
                                    r_data    <= w_meta;
                                    r_data_wr <= 1'b1;
                                    r_fwd     <= 1'b1;
                                end
                            end else begin
                                r_state <= S_DROP;
                            end
                        end
                    end
                end

                S_FIRST: begin
                    if (i_pkt_data_wr) begin
                        r_state <= S_BODY;
                        if (r_replace) begin
                            r_data    <= w_repl_word;
                            r_data_wr <= 1'b1;
                        end else if (!w_tail) begin
                            // header word discarded; metadata takes its slot
                            r_data    <= w_meta;
                            r_data_wr <= 1'b1;
                            r_fwd     <= 1'b1;
                        end
                    end
                end

                S_BODY: begin
                    if (i_pkt_data_wr) begin
                        r_data    <= iv_pkt_data;
                        r_data_wr <= 1'b1;
                    end
                end

                S_DROP: begin
                    // fetched words are swallowed until the tail
                end

                S_RELEASE: begin
                    if (r_fwd) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    else       r_drop_cnt  <= r_drop_cnt + CNT_W'(1);
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase

            // Tail in any data-phase state: release the buffer next cycle
            if (w_frame_state && i_pkt_data_wr && w_tail) begin
                r_state      <= S_RELEASE;
                r_free_wr    <= 1'b1;
                r_free_bufid <= r_bufid;
            end
        end
    end

    assign o_descriptor_ready = r_ready;
    assign ov_pkt_rd_bufid    = r_rd_bufid;
    assign o_pkt_rd           = r_pkt_rd;
    assign ov_free_bufid      = r_free_bufid;
    assign o_free_bufid_wr    = r_free_wr;
    assign ov_data            = r_data;
    assign o_data_wr          = r_data_wr;
    assign ov_frame_cnt       = r_frame_cnt;
    assign ov_drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_host_frame_rebuild.sv
// Directed bench for host_frame_rebuild: first/middle/miss fragments,
// FIFO backpressure, metadata-only drop, mid-frame reset and counter wrap.
module tb_host_frame_rebuild;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [47:0]  iv_dmac;
    logic [8:0]   iv_bufid;
    logic         i_lookup_table_match_flag;
    logic         i_dmac_replace_flag;
    logic         i_descriptor_wr;
    logic         o_descriptor_ready;
    logic [8:0]   ov_pkt_rd_bufid;
    logic         o_pkt_rd;
    logic [133:0] iv_pkt_data;
    logic         i_pkt_data_wr;
    logic [8:0]   ov_free_bufid;
    logic         o_free_bufid_wr;
    logic         i_fifo_afull;
    logic [133:0] ov_data;
    logic         o_data_wr;
    logic [15:0]  ov_frame_cnt;
    logic [15:0]  ov_drop_cnt;

    host_frame_rebuild dut (
        .i_clk                     (i_clk),
        .i_rst                     (i_rst),
        .iv_dmac                   (iv_dmac),
        .iv_bufid                  (iv_bufid),
        .i_lookup_table_match_flag (i_lookup_table_match_flag),
        .i_dmac_replace_flag       (i_dmac_replace_flag),
        .i_descriptor_wr           (i_descriptor_wr),
        .o_descriptor_ready        (o_descriptor_ready),
        .ov_pkt_rd_bufid           (ov_pkt_rd_bufid),
        .o_pkt_rd                  (o_pkt_rd),
        .iv_pkt_data               (iv_pkt_data),
        .i_pkt_data_wr             (i_pkt_data_wr),
        .ov_free_bufid             (ov_free_bufid),
        .o_free_bufid_wr           (o_free_bufid_wr),
        .i_fifo_afull              (i_fifo_afull),
        .ov_data                   (ov_data),
        .o_data_wr                 (o_data_wr),
        .ov_frame_cnt              (ov_frame_cnt),
        .ov_drop_cnt               (ov_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [133:0] pk [0:7];
    logic [133:0] oq [$];
    logic [8:0]   fq [$];

    // Capture output words and release strobes between clock edges
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_data_wr)       oq.push_back(ov_data);
            if (o_free_bufid_wr) fq.push_back(ov_free_bufid);
        end
    end

    task automatic chk(input string tag, input logic [133:0] act, input logic [133:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [133:0] oq_at(input int i);
        return (oq.size() > i) ? oq[i] : 'x;
    endfunction

    function automatic logic [133:0] fq_at(input int i);
        return (fq.size() > i) ? {125'd0, fq[i]} : 'x;
    endfunction

    task automatic send_desc(input logic [47:0] d, input logic [8:0] b, input logic m, input logic r);
        @(negedge i_clk);
        chk("ready_before_desc", {133'd0, o_descriptor_ready}, 134'd1);
        iv_dmac = d; iv_bufid = b;
        i_lookup_table_match_flag = m; i_dmac_replace_flag = r;
        i_descriptor_wr = 1'b1;
        @(negedge i_clk);
        i_descriptor_wr = 1'b0;
    endtask

    task automatic wait_rd(input logic [8:0] b);
        int k = 0;
        while (!o_pkt_rd && k < 40) begin
            @(negedge i_clk);
            k++;
        end
        chk("rd_seen", {133'd0, o_pkt_rd}, 134'd1);
        chk("rd_bufid", {125'd0, ov_pkt_rd_bufid}, {125'd0, b});
    endtask

    // Buffer answers one cycle after the read request
    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            iv_pkt_data = pk[i];
            i_pkt_data_wr = 1'b1;
        end
        @(negedge i_clk);
        i_pkt_data_wr = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(negedge i_clk);
    endtask

    task automatic clear_q();
        oq.delete();
        fq.delete();
    endtask

    initial begin
        int bad;
        i_rst = 1'b1;
        iv_dmac = '0; iv_bufid = '0;
        i_lookup_table_match_flag = 1'b0; i_dmac_replace_flag = 1'b0;
        i_descriptor_wr = 1'b0; iv_pkt_data = '0; i_pkt_data_wr = 1'b0;
        i_fifo_afull = 1'b0;

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_ready", {133'd0, o_descriptor_ready}, 134'd1);
        chk("rst_data_wr", {133'd0, o_data_wr}, 134'd0);
        chk("rst_rd", {133'd0, o_pkt_rd}, 134'd0);
        chk("rst_cnts", {102'd0, ov_frame_cnt, ov_drop_cnt}, 134'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("ready_after_rst", {133'd0, o_descriptor_ready}, 134'd1);

        // 1: first fragment, tag replaced
        clear_q();
        pk[0] = {2'b01, 4'h0, 48'hAAAA_BBBB_CCCC, 80'h1111};
        pk[1] = {2'b00, 4'h0, 128'h2222};
        pk[2] = {2'b00, 4'h0, 128'h3333};
        pk[3] = {2'b10, 4'h5, 128'h4444};
        send_desc(48'h0011_2233_4455, 9'h005, 1'b1, 1'b1);
        wait_rd(9'h005);
        feed(4);
        settle();
        chk("t1_count", oq.size(), 134'd5);
        chk("t1_meta", oq_at(0), {2'b01, 4'h0, 48'h0011_2233_4455, 9'h005, 1'b1, 70'd0});
        chk("t1_w1", oq_at(1), {2'b00, 4'h0, 48'h0011_2233_4455, 80'h1111});
        chk("t1_w2", oq_at(2), {2'b00, 4'h0, 128'h2222});
        chk("t1_w3", oq_at(3), {2'b00, 4'h0, 128'h3333});
        chk("t1_w4", oq_at(4), {2'b10, 4'h5, 128'h4444});
        chk("t1_free", fq_at(0), 134'h005);
        chk("t1_free_n", fq.size(), 134'd1);
        chk("t1_frame_cnt", {118'd0, ov_frame_cnt}, 134'd1);

        // 2: middle fragment, header word dropped
        clear_q();
        pk[0] = {2'b01, 4'h0, 48'hAAAA_BBBB_CCCC, 80'h22};
        pk[1] = {2'b00, 4'h0, 128'h33};
        pk[2] = {2'b10, 4'h7, 128'h44};
        send_desc(48'hDEAD_BEEF_0102, 9'h1FF, 1'b1, 1'b0);
        wait_rd(9'h1FF);
        feed(3);
        settle();
        chk("t2_count", oq.size(), 134'd3);
        chk("t2_meta", oq_at(0), {2'b01, 4'h0, 48'hDEAD_BEEF_0102, 9'h1FF, 1'b0, 70'd0});
        chk("t2_w1", oq_at(1), {2'b00, 4'h0, 128'h33});
        chk("t2_w2", oq_at(2), {2'b10, 4'h7, 128'h44});
        chk("t2_free", fq_at(0), 134'h1FF);
        chk("t2_frame_cnt", {118'd0, ov_frame_cnt}, 134'd2);

        // 3: lookup miss
        clear_q();
        pk[0] = {2'b01, 4'h0, 128'h5};
        for (int i = 1; i < 4; i++) pk[i] = {2'b00, 4'h0, 128'(i)};
        pk[4] = {2'b10, 4'h0, 128'h9};
        send_desc(48'h1234_5678_9ABC, 9'h007, 1'b0, 1'b0);
        wait_rd(9'h007);
        feed(5);
        settle();
        chk("t3_count", oq.size(), 134'd0);
        chk("t3_free", fq_at(0), 134'h007);
        chk("t3_free_n", fq.size(), 134'd1);
        chk("t3_drop_cnt", {118'd0, ov_drop_cnt}, 134'd1);
        chk("t3_frame_cnt", {118'd0, ov_frame_cnt}, 134'd2);

        // 4: FIFO almost-full holds the read off
        clear_q();
        i_fifo_afull = 1'b1;
        pk[0] = {2'b11, 4'h2, 48'hAAAA_BBBB_CCCC, 80'h55};
        send_desc(48'h0A0B_0C0D_0E0F, 9'h00A, 1'b1, 1'b1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_pkt_rd || o_descriptor_ready || o_data_wr) bad++;
            @(negedge i_clk);
        end
        chk("t4_hold", bad, 134'd0);
        i_fifo_afull = 1'b0;
        @(negedge i_clk);
        chk("t4_rd_after", {133'd0, o_pkt_rd}, 134'd1);
        chk("t4_rd_bufid", {125'd0, ov_pkt_rd_bufid}, 134'h00A);
        feed(1);
        settle();
        chk("t4_count", oq.size(), 134'd2);
        chk("t4_meta", oq_at(0), {2'b01, 4'h0, 48'h0A0B_0C0D_0E0F, 9'h00A, 1'b1, 70'd0});
        chk("t4_w0", oq_at(1), {2'b10, 4'h2, 48'h0A0B_0C0D_0E0F, 80'h55});
        chk("t4_frame_cnt", {118'd0, ov_frame_cnt}, 134'd3);

        // 5: single-word non-first fragment -> metadata-only, dropped
        clear_q();
        pk[0] = {2'b11, 4'h0, 128'h77};
        send_desc(48'h5555_6666_7777, 9'h033, 1'b1, 1'b0);
        wait_rd(9'h033);
        feed(1);
        settle();
        chk("t5_count", oq.size(), 134'd0);
        chk("t5_free", fq_at(0), 134'h033);
        chk("t5_drop_cnt", {118'd0, ov_drop_cnt}, 134'd2);
        chk("t5_frame_cnt", {118'd0, ov_frame_cnt}, 134'd3);

        // 6: reset in the middle of a frame
        pk[0] = {2'b01, 4'h0, 128'h1};
        pk[1] = {2'b00, 4'h0, 128'h2};
        send_desc(48'h0102_0304_0506, 9'h003, 1'b1, 1'b1);
        wait_rd(9'h003);
        feed(2);
        i_pkt_data_wr = 1'b1;
        iv_pkt_data = {2'b00, 4'h0, 128'h3};
        i_rst = 1'b1;
        #1;
        chk("t6_rst_data_wr", {133'd0, o_data_wr}, 134'd0);
        chk("t6_rst_ready", {133'd0, o_descriptor_ready}, 134'd1);
        chk("t6_rst_cnts", {102'd0, ov_frame_cnt, ov_drop_cnt}, 134'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        clear_q();
        pk[0] = {2'b00, 4'h0, 128'h4};
        pk[1] = {2'b10, 4'h0, 128'h5};
        feed(2);
        settle();
        chk("t6_stray_out", oq.size(), 134'd0);
        chk("t6_stray_free", fq.size(), 134'd0);
        chk("t6_ready", {133'd0, o_descriptor_ready}, 134'd1);

        // Drop counter wrap: preload near the top instead of 65535 frames
        force dut.r_drop_cnt = 16'hFFFF;
        @(negedge i_clk);
        release dut.r_drop_cnt;
        @(negedge i_clk);
        chk("t6_drop_pre", {118'd0, ov_drop_cnt}, 134'hFFFF);
        clear_q();
        pk[0] = {2'b01, 4'h0, 128'h6};
        pk[1] = {2'b10, 4'h0, 128'h7};
        send_desc(48'h0, 9'h044, 1'b0, 1'b0);
        wait_rd(9'h044);
        feed(2);
        settle();
        chk("t6_drop_wrap", {118'd0, ov_drop_cnt}, 134'd0);
        chk("t6_free", fq_at(0), 134'h044);
        chk("t6_count", oq.size(), 134'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
